i2s_rx_tdm: RTL and testbench

//  Parametrised serial-audio receiver for user-port audio sources (MT32-pi and similar).

---
 rtl/i2s_rx_tdm.sv | 94 +++++++++
 tb/tb_i2s_rx_tdm.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/i2s_rx_tdm.sv
// i2s_rx_tdm: I2S/TDM serial audio receiver emitting slot-tagged, strobe-qualified samples
module i2s_rx_tdm #(
  parameter int WIDTH = 16,
  parameter int SLOTS = 2,
  parameter int SLOT_BITS = 32,
  parameter int MODE = 0,
  parameter int DEBOUNCE = 1,
  localparam int SW = ($clog2(SLOTS) > 0) ? $clog2(SLOTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bclk,
  input  logic             ws,
  input  logic             sdat,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_slot,
  output logic             out_valid,
  output logic             locked,
  output logic             err
);
  localparam int FRAME = SLOTS * SLOT_BITS;
  localparam int BMAX = (MODE != 0) ? SLOT_BITS : WIDTH;
  localparam int BW = $clog2(BMAX + 1);
  localparam int FW = $clog2(FRAME + 2);
  localparam int CW = $clog2(SLOTS + 1);
  logic [2:0] s1, s2, s3, fq, f, agree;
  logic rise, primed, pws, bnd, last, commit, err_set;
  logic [WIDTH-1:0] shreg, nsr;
  logic [BW-1:0] bc;
  logic [CW-1:0] sc;
  logic [FW-1:0] fc;
  // {bclk, ws, sdat}: a filtered level only moves once two synchronised samples agree
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2, s3, fq} <= '0;
    else begin
      s1 <= {bclk, ws, sdat};
      s2 <= s1;
      s3 <= s2;
      fq <= f;
    end
  always_comb begin
    agree = ~(s2 ^ s3);
    f = (DEBOUNCE != 0) ? ((s2 & agree) | (fq & ~agree)) : s2;
    rise = f[2] & ~fq[2];
    nsr = (int'(bc) < WIDTH) ? (shreg | (WIDTH'(f[0]) << (WIDTH - 1 - int'(bc)))) : shreg;
    bnd = primed & ((MODE != 0) ? (f[1] & ~pws) : (f[1] ^ pws));
    last = (MODE != 0) ? (int'(bc) == SLOT_BITS - 1 && int'(sc) < SLOTS) : bnd;
    commit = rise & last & locked;
    err_set = rise & bnd & locked & (MODE != 0) & (int'(fc) != FRAME - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      primed <= 1'b0;
      pws <= 1'b0;
      locked <= 1'b0;
      err <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_slot <= '0;
      shreg <= '0;
      bc <= '0;
      sc <= '0;
      fc <= '0;
    end else begin
      out_valid <= commit;
      err <= err_set | (err & ~err_clr);
      if (commit) begin
        out_data <= nsr;
        out_slot <= (MODE != 0) ? SW'(sc) : SW'(pws);
      end
      if (rise) begin
        primed <= 1'b1;
        pws <= f[1];
        if (bnd) begin
          locked <= 1'b1;
          shreg <= '0;
          bc <= '0;
          sc <= '0;
          fc <= '0;
        end else begin
          fc <= (&fc) ? fc : fc + 1'b1;
          if (MODE != 0 && last) begin
            shreg <= '0;
            bc <= '0;
            sc <= sc + 1'b1;
          end else if ((MODE != 0) ? (int'(sc) < SLOTS) : (int'(bc) < WIDTH)) begin
            shreg <= nsr;
            bc <= bc + 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_i2s_rx_tdm.sv
// tb_i2s_rx_tdm: I2S and TDM receivers driven from word tables, checked through strobe scoreboards
module tb_i2s_rx_tdm;
  logic clk = 0, rst0 = 1, rst1 = 1, err_clr0 = 0, err_clr1 = 0;
  logic bclk0 = 0, ws0 = 0, sdat0 = 0, bclk1 = 0, ws1 = 0, sdat1 = 0;
  logic [15:0] out_data0, out_data1;
  logic out_slot0;
  logic [2:0] out_slot1;
  logic out_valid0, out_valid1, locked0, locked1, err0, err1;
  logic pv0 = 0, pv1 = 0;
  int n_cmp = 0, n_bad = 0;
  typedef struct {int slot; int data;} exp_t;
  typedef struct {int nbits; logic [31:0] value; int glitch; logic [15:0] exp;} vec_t;
  exp_t q0[$], q1[$];
  vec_t vec[9];
  always #5 clk = ~clk;
  i2s_rx_tdm #(.WIDTH(16), .SLOTS(2), .SLOT_BITS(32), .MODE(0), .DEBOUNCE(1)) d0 (
    .clk(clk), .reset(rst0), .bclk(bclk0), .ws(ws0), .sdat(sdat0), .err_clr(err_clr0),
    .out_data(out_data0), .out_slot(out_slot0), .out_valid(out_valid0), .locked(locked0), .err(err0));
  i2s_rx_tdm #(.WIDTH(16), .SLOTS(8), .SLOT_BITS(32), .MODE(1), .DEBOUNCE(1)) d1 (
    .clk(clk), .reset(rst1), .bclk(bclk1), .ws(ws1), .sdat(sdat1), .err_clr(err_clr1),
    .out_data(out_data1), .out_slot(out_slot1), .out_valid(out_valid1), .locked(locked1), .err(err1));
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (out_valid0) begin
      chk("consec0", pv0, 0);
      if (q0.size() == 0) chk("spurious0", 1, 0);
      else begin
        e = q0.pop_front();
        chk("slot0", out_slot0, e.slot);
        chk("data0", out_data0, e.data);
      end
    end
    if (out_valid1) begin
      chk("consec1", pv1, 0);
      if (q1.size() == 0) chk("spurious1", 1, 0);
      else begin
        e = q1.pop_front();
        chk("slot1", out_slot1, e.slot);
        chk("data1", out_data1, e.data);
      end
    end
    pv0 = out_valid0;
    pv1 = out_valid1;
  end
  task automatic bit0(input logic w, input logic d, input bit g, input bit lat);
    bclk0 = 0; ws0 = w; sdat0 = d;
    if (g) begin #10 bclk0 = 1; #10 bclk0 = 0; #20; end
    else #40;
    bclk0 = 1;
    if (lat) begin
      #30 chk("lat_pre", out_valid0, 0);
      #10 chk("lat_on", out_valid0, 1);
    end else #40;
  endtask
  task automatic word0(input int n, input logic [31:0] v, input logic c, input int g, input bit lat);
    for (int i = 0; i < n; i++) bit0((i == n - 1) ? ~c : c, v[n - 1 - i], i == g, lat && i == n - 1);
  endtask
  function automatic logic [31:0] slotw(input int s);
    return {16'(16'h1110 * s), 16'hC3C3 ^ 16'(s)};
  endfunction
  task automatic frame1(input int n, input bit push);
    logic [31:0] w;
    if (push) for (int s = 0; s < 8 && s < n / 32; s++) q1.push_back('{s, int'(16'h1110 * s)});
    for (int b = 0; b < n; b++) begin
      w = (b / 32 < 8) ? slotw(b / 32) : 32'h0;
      bclk1 = 0; ws1 = (b == n - 1); sdat1 = w[31 - b % 32];
      #40 bclk1 = 1;
      #40;
    end
  endtask
  initial begin
    vec[0] = '{16, 32'h0000A55A, -1, 16'hA55A};
    vec[1] = '{16, 32'h00001234, -1, 16'h1234};
    vec[2] = '{24, 32'h0089ABCD, -1, 16'h89AB};
    vec[3] = '{8, 32'h0000007F, -1, 16'h7F00};
    vec[4] = '{16, 32'h00008001, -1, 16'h8001};
    vec[5] = '{32, 32'hFFFF0000, -1, 16'hFFFF};
    vec[6] = '{16, 32'h00003C96, 5, 16'h3C96};
    vec[7] = '{16, 32'h00000000, -1, 16'h0000};
    vec[8] = '{16, 32'h0000C3A5, 9, 16'hC3A5};
    #50;
    chk("rst_data0", out_data0, 0);
    chk("rst_valid0", out_valid0, 0);
    chk("rst_locked0", locked0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_data1", out_data1, 0);
    chk("rst_slot1", out_slot1, 0);
    chk("rst_locked1", locked1, 0);
    chk("rst_err1", err1, 0);
    #50 rst0 = 0; rst1 = 0;
    #40;
    word0(16, 32'h0F0F, 1'b1, -1, 0);
    chk("lock0", locked0, 1);
    for (int i = 0; i < 9; i++) begin
      q0.push_back('{i % 2, int'(vec[i].exp)});
      word0(vec[i].nbits, vec[i].value, 1'(i % 2), vec[i].glitch, 1);
    end
    #200;
    chk("hold0", out_data0, 16'hC3A5);
    chk("q0_empty", q0.size(), 0);
    chk("err0_i2s", err0, 0);
    for (int i = 0; i < 8; i++) bit0(1'b1, 1'(i % 2), 0, 0);
    rst0 = 1; bclk0 = 0;
    #1;
    chk("mid_data0", out_data0, 0);
    chk("mid_slot0", out_slot0, 0);
    chk("mid_valid0", out_valid0, 0);
    chk("mid_locked0", locked0, 0);
    #9 rst0 = 0;
    #40;
    word0(16, 32'hDEAD, 1'b1, -1, 0);
    chk("relock0", locked0, 1);
    q0.push_back('{0, 16'h5A5A});
    word0(16, 32'h5A5A, 1'b0, -1, 1);
    #100 chk("q0_final", q0.size(), 0);
    frame1(40, 0);
    chk("lock1", locked1, 1);
    frame1(256, 1);
    frame1(256, 1);
    #40;
    chk("err1_good", err1, 0);
    chk("q1_good", q1.size(), 0);
    frame1(200, 1);
    #40;
    chk("err1_trunc", err1, 1);
    chk("q1_trunc", q1.size(), 0);
    err_clr1 = 1;
    #10 err_clr1 = 0;
    #10 chk("err1_clr", err1, 0);
    frame1(256, 1);
    #40;
    chk("err1_after", err1, 0);
    chk("q1_after", q1.size(), 0);
    #200 chk("hold1", out_data1, 16'h7770);
    chk("locked1_end", locked1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
